// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART-framed debug bus initiator: W/R command frames drive the memory-mapped bus
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int WR_HOLD        = 32,
    parameter int RD_LAT         = 2
) (
    input  logic        CLK_100MHz,
    input  logic        RESET_N,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_clear,
    output logic [15:0] tx_data,
    output logic        tx_load,
    input  logic        tx_busy,
    output logic [15:0] address,
    output logic [15:0] dataW,
    output logic        loadM,
    input  logic [15:0] dataR,
    output logic        bus_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(WR_HOLD + RD_LAT + 1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
        S_WRITE, S_READ_WAIT, S_TX_ACK, S_TX_HI, S_TX_LO, S_TX_NAK
    } state_t;

    typedef enum logic [1:0] {P_WAIT_IDLE, P_WAIT_BUSY, P_WAIT_DONE} tx_phase_t;

    state_t          state;
    tx_phase_t       tx_phase;
    logic [1:0]      tx_wait;
    logic [TW-1:0]   tmo_cnt;
    logic [SW-1:0]   step_cnt;
    logic [7:0]      cmd, addr_h, addr_l, data_h;
    logic [15:0]     rd_latch;
    logic            in_frame, take, tmo_hit, tx_last;
    logic [7:0]      tx_byte;

    // rx_clear doubles as the "ignore rx_ready this cycle" flag while UartRX drops its level
    always_comb begin
        in_frame = (state == S_ADDR_H) || (state == S_ADDR_L) ||
                   (state == S_DATA_H) || (state == S_DATA_L);
        take     = (in_frame || state == S_IDLE) && rx_ready && !rx_clear;
        tmo_hit  = in_frame && (tmo_cnt >= TW'(TIMEOUT_CYCLES - 1));
        tx_last  = (state != S_TX_HI);
        case (state)
            S_TX_ACK: tx_byte = 8'h06;
            S_TX_NAK: tx_byte = 8'h15;
            S_TX_HI:  tx_byte = rd_latch[15:8];
            S_TX_LO:  tx_byte = rd_latch[7:0];
            default:  tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            tx_phase <= P_WAIT_IDLE;
            tx_wait  <= '0;
            tmo_cnt  <= '0;
            step_cnt <= '0;
            cmd      <= '0;
            addr_h   <= '0;
            addr_l   <= '0;
            data_h   <= '0;
            rd_latch <= '0;
            rx_clear <= 1'b0;
            tx_data  <= '0;
            tx_load  <= 1'b0;
            address  <= '0;
            dataW    <= '0;
            loadM    <= 1'b0;
            bus_busy <= 1'b0;
        end else begin
            rx_clear <= 1'b0;
            tx_load  <= 1'b0;
            if (take && !tmo_hit) begin
                rx_clear <= 1'b1;
                tmo_cnt  <= '0;
            end else if (in_frame) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            case (state)
                S_IDLE: if (take) begin
                    cmd      <= rx_data;
                    bus_busy <= 1'b1;
                    state    <= S_CMD;
                end
                S_CMD: begin
                    tx_phase <= P_WAIT_IDLE;
                    state    <= (cmd == CMD_W || cmd == CMD_R) ? S_ADDR_H : S_TX_NAK;
                end
                S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L: begin
                    // Timeout wins over a simultaneous byte; that byte stays in UartRX
                    if (tmo_hit) begin
                        state    <= S_IDLE;
                        bus_busy <= 1'b0;
                    end else if (take) begin
                        step_cnt <= '0;
                        case (state)
                            S_ADDR_H: begin
                                addr_h <= rx_data;
                                state  <= S_ADDR_L;
                            end
                            S_ADDR_L: begin
                                addr_l <= rx_data;
                                if (cmd == CMD_W) begin
                                    state <= S_DATA_H;
                                end else begin
                                    address <= {addr_h, rx_data};
                                    state   <= S_READ_WAIT;
                                end
                            end
                            S_DATA_H: begin
                                data_h <= rx_data;
                                state  <= S_DATA_L;
                            end
                            default: begin
                                address <= {addr_h, addr_l};
                                dataW   <= {data_h, rx_data};
                                loadM   <= 1'b1;
                                state   <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (step_cnt == SW'(WR_HOLD - 1)) begin
                        loadM <= 1'b0;
                        state <= S_TX_ACK;
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                S_READ_WAIT: begin
                    if (step_cnt == SW'(RD_LAT - 1)) begin
                        rd_latch <= dataR;
                        state    <= S_TX_HI;
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                default: begin
                    // Per byte: idle -> load pulse -> busy rise (up to 4 clks) -> busy fall
                    case (tx_phase)
                        P_WAIT_IDLE: if (!tx_busy) begin
                            tx_load  <= 1'b1;
                            tx_data  <= {8'h00, tx_byte};
                            tx_wait  <= '0;
                            tx_phase <= P_WAIT_BUSY;
                        end
                        P_WAIT_BUSY: begin
                            if (tx_busy || tx_wait == 2'd3) tx_phase <= P_WAIT_DONE;
                            else                             tx_wait  <= tx_wait + 2'd1;
                        end
                        default: if (!tx_busy) begin
                            tx_phase <= P_WAIT_IDLE;
                            if (tx_last) begin
                                state    <= S_IDLE;
                                bus_busy <= 1'b0;
                            end else begin
                                state <= S_TX_LO;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule
